sr_flag_arbiter: RTL and testbench
==================================

# sr_flag_arbiter

Round-robin arbiter and pulse sequencer that shares one `sr_ff` status latch among N requesters. Each requester asks to set or clear the shared flag. The block grants one requester at a time and drives the latch's `s`/`r` inputs with a fixed-width pulse. It then confirms the result on `q`/`qn` before releasing the grant. It sits between requesting logic and the `sr_ff` instance, driving that instance's `clk`-gated `s`/`r` inputs from the system clock domain.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `PULSE_CYC`, 2: cycles `s_out`/`r_out` is held high per operation, ≥1.
- `TIMEOUT`, 8: maximum CHECK cycles waiting for `q_in`/`qn_in` to confirm, ≥1.
- `OW`, `$clog2(N_REQ)`: owner index width (derived).

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `set_req` in N_REQ: level request per requester to set the flag.
- `clr_req` in N_REQ: level request per requester to clear the flag.
- `grant` out N_REQ: one-hot owner; zero when idle.
- `owner` out OW: index of the granted requester; valid while `busy`.
- `busy` out 1: high from grant until the cycle after done/err.
- `done` out 1: one-cycle pulse, operation confirmed.
- `err` out 1: one-cycle pulse, confirmation timed out.
- `s_out` out 1: to latch `s`.
- `r_out` out 1: to latch `r`.
- `q_in` in 1: from latch `q`.
- `qn_in` in 1: from latch `qn`.

## Operation
- FSM states: IDLE, PULSE, CHECK, DONE, ERR. All outputs are registered.
- **IDLE**
  - A requester is active if `set_req[i] | clr_req[i]`.
  - Pick the first active index at or above `ptr`, wrapping modulo N_REQ.
  - Latch `owner`, one-hot `grant`, and the operation. If both `set_req[i]` and `clr_req[i]` are high, the operation is set (set has priority, matching latch priority).
  - Go to PULSE and load the pulse counter with PULSE_CYC.
- **PULSE**
  - Drive `s_out=1` for a set, or `r_out=1` for a clear. Never both.
  - Count down. At zero, deassert and go to CHECK with the timeout counter cleared.
- **CHECK**
  - Match means: set → `q_in=1, qn_in=0`; clear → `q_in=0, qn_in=1`. `q_in==qn_in` is never a match.
  - On match, go to DONE.
  - Otherwise increment the counter. After TIMEOUT non-matching cycles, go to ERR.
- **DONE / ERR**
  - Assert `done` or `err` for one cycle, with `grant` still held.
  - Set `ptr = (owner+1) mod N_REQ`.
  - Return to IDLE.
- Request lines are sampled only in IDLE. Withdrawal or change during an operation is ignored, and the operation runs to completion.
- The latch has no reset. The block makes no assumption about flag state after `rst` and always pulses; no skip-if-already-set.

## Timing
- Reset values: `grant=0`, `owner=0`, `busy=0`, `done=0`, `err=0`, `s_out=0`, `r_out=0`. State is IDLE and `ptr=0`.
- `rst` mid-operation drops `s_out`/`r_out`/`grant` at that edge with no `done`/`err`. The truncated pulse's effect on the latch is undefined.
- Request high in IDLE at edge 0 produces:
  - `grant`/`busy`/pulse high from edge 1;
  - pulse high for cycles 1..PULSE_CYC;
  - CHECK from cycle PULSE_CYC+1;
  - with an immediate match, `done` at cycle PULSE_CYC+2;
  - IDLE at PULSE_CYC+3, earliest next grant at PULSE_CYC+4.
- Worst case to `err`: cycle PULSE_CYC+TIMEOUT+1.
- `busy` falls the same edge `grant` clears, which is the cycle after the `done`/`err` pulse.
- `s_out` and `r_out` are never high in the same cycle, and are never high outside PULSE.

## Test plan
- **Reset:** assert `rst` 2 cycles with requests pending → all outputs 0. Release → first grant to index 0 if `set_req[0]` is active.
- **Single set:** N_REQ=4, PULSE_CYC=2, `set_req=4'b0100` at cycle 0, latch model responds → `grant=4'b0100` cycles 1–4, `s_out` high cycles 1–2, `done` at cycle 4, `busy` low from cycle 5.
- **Round-robin:** requests held `4'b1011` continuously → grant order 0,1,3,0,1,3. No index is granted twice while another is waiting.
- **Set/clear conflict:** `set_req[2]=clr_req[2]=1` → `s_out` pulses, `r_out` stays 0, `done` with `q_in=1`.
- **Timeout:** `q_in`/`qn_in` held at 0/0 after a set → no `done`, `err` pulse at cycle PULSE_CYC+TIMEOUT+1 = 11, `ptr` advances to owner+1.
- **Reset mid-pulse:** `rst` at cycle 1 of PULSE → `s_out=0` next edge, no `done`/`err`, `ptr=0`, re-arbitration after release.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that shares one SR status latch among N_REQ requesters.
// It grants one requester, pulses s/r for PULSE_CYC cycles, then confirms on q/qn before release.
module sr_flag_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned TIMEOUT   = 8,
  parameter int unsigned OW        = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] set_req,
  input  logic [N_REQ-1:0] clr_req,
  output logic [N_REQ-1:0] grant,
  output logic [OW-1:0]    owner,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             s_out,
  output logic             r_out,
  input  logic             q_in,
  input  logic             qn_in
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PULSE = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  localparam int unsigned PW = $clog2(PULSE_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PULSE_LOAD   = PW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [OW-1:0] OWNER_LAST   = OW'(N_REQ - 1);

  logic [2:0]       state_q, state_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             op_set_q, op_set_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             s_q, s_d;
  logic             r_q, r_d;

  logic [N_REQ-1:0] active;
  logic             pick_valid;
  logic [OW-1:0]    pick_idx;
  logic             match;

  assign active = set_req | clr_req;

  // Both rails must agree with the requested value; q == qn is never a confirmation.
  assign match = op_set_q ? (q_in & ~qn_in) : (~q_in & qn_in);

  // First active requester at or above ptr, wrapping modulo N_REQ.
  always_comb begin : arbitrate
    int unsigned idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!pick_valid && active[OW'(idx)]) begin
        pick_valid = 1'b1;
        pick_idx   = OW'(idx);
      end
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    op_set_d = op_set_q;
    pcnt_d   = pcnt_q;
    tcnt_d   = tcnt_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d  = pick_idx;
          grant_d  = N_REQ'(1) << pick_idx;
          // Set wins a set/clear conflict, mirroring the latch's own priority.
          op_set_d = set_req[pick_idx];
          pcnt_d   = PULSE_LOAD;
          state_d  = PULSE;
        end
      end
      PULSE: begin
        if (pcnt_q == '0) begin
          tcnt_d  = '0;
          state_d = CHECK;
        end else begin
          pcnt_d = pcnt_q - PW'(1);
        end
      end
      CHECK: begin
        if (match) begin
          state_d = DONE;
        end else if (tcnt_q == TIMEOUT_LAST) begin
          state_d = ERR;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      DONE, ERR: begin
        grant_d = '0;
        ptr_d   = (owner_q == OWNER_LAST) ? '0 : owner_q + OW'(1);
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered copies decoded from the next state.
  always_comb begin : next_outputs
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
    s_d    = (state_d == PULSE) & op_set_d;
    r_d    = (state_d == PULSE) & ~op_set_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      op_set_q <= 1'b0;
      pcnt_q   <= '0;
      tcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      op_set_q <= op_set_d;
      pcnt_q   <= pcnt_d;
      tcnt_q   <= tcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      s_q      <= s_d;
      r_q      <= r_d;
    end
  end

  assign grant = grant_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign s_out = s_q;
  assign r_out = r_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: a timeline model of each grant checked every cycle, plus
// directed scenarios with hand-computed cycle expectations and a small SR latch stand-in.
module tb_sr_flag_arbiter;

  localparam int N = 4;
  localparam int P = 2;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] set_req = '0;
  logic [3:0] clr_req = '0;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy, done, err, s_out, r_out;
  logic       q_in, qn_in;

  logic stuck = 1'b0;
  logic lq = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_flag_arbiter #(
    .N_REQ(N),
    .PULSE_CYC(P),
    .TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .set_req(set_req),
    .clr_req(clr_req),
    .grant(grant),
    .owner(owner),
    .busy(busy),
    .done(done),
    .err(err),
    .s_out(s_out),
    .r_out(r_out),
    .q_in(q_in),
    .qn_in(qn_in)
  );

  // Latch stand-in: set dominates; 'stuck' forces both rails low to provoke a timeout.
  always @(posedge clk) begin
    if (s_out === 1'b1) lq <= 1'b1;
    else if (r_out === 1'b1) lq <= 1'b0;
  end
  assign q_in  = stuck ? 1'b0 : lq;
  assign qn_in = stuck ? 1'b0 : ~lq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: each grant is a timeline indexed by age (1 = first granted cycle).
  // Pulse occupies ages 1..P, confirmation window ages P+1..P+T, terminal pulse one
  // cycle after the deciding sample, release the cycle after that.
  bit         m_valid = 0;
  bit         m_active = 0;
  bit         m_set = 0;
  bit         m_err = 0;
  int         m_owner = 0;
  int         m_ptr = 0;
  int         m_age = 0;
  int         m_end = 0;
  logic [3:0] m_grant;
  logic [1:0] m_pulse;
  logic [1:0] m_term;

  always @(negedge clk) begin
    if (m_valid) begin
      m_grant = m_active ? (4'b0001 << m_owner) : 4'b0000;
      m_pulse = (m_active && m_age <= P) ? (m_set ? 2'b10 : 2'b01) : 2'b00;
      m_term  = (m_active && m_age == m_end) ? (m_err ? 2'b01 : 2'b10) : 2'b00;
      chk("grant", grant, m_grant);
      chk("busy", busy, m_active);
      if (m_active) chk("owner", owner, m_owner);
      chk("s_r_pulse", {s_out, r_out}, m_pulse);
      chk("done_err", {done, err}, m_term);
    end
    if (rst) begin
      m_valid  = 1;
      m_active = 0;
      m_owner  = 0;
      m_ptr    = 0;
    end else if (!m_active) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (!m_active && (set_req[j] || clr_req[j])) begin
          m_active = 1;
          m_owner  = j;
          m_set    = set_req[j];
          m_age    = 1;
          m_end    = 0;
        end
      end
    end else if (m_age == m_end) begin
      m_active = 0;
      m_ptr    = (m_owner + 1) % N;
    end else begin
      if (m_age > P && m_end == 0) begin
        if (m_set ? (q_in && !qn_in) : (!q_in && qn_in)) begin
          m_end = m_age + 1;
          m_err = 0;
        end else if (m_age == P + T) begin
          m_end = m_age + 1;
          m_err = 1;
        end
      end
      m_age++;
    end
  end

  logic [3:0] g_rec[1:5];
  logic       s_rec[1:5];
  logic       d_rec[1:5];
  logic       b_rec[1:5];
  int         order[$];
  int         exp_rr[6] = '{0, 1, 3, 0, 1, 3};
  logic       prev_busy;
  logic       seen_s, seen_r, seen_d, q_at_done;
  int         err_cyc;

  initial begin
    // Reset held two edges with a request pending.
    set_req = 4'b0001;
    rst = 1'b1;
    step();
    step();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_outs", {done, err, s_out, r_out}, 4'b0000);
    rst = 1'b0;
    step();
    chk("first_grant", grant, 4'b0001);
    set_req = 4'b0000;
    repeat (6) step();

    // Single set on index 2; request withdrawn after the grant.
    set_req = 4'b0100;
    for (int k = 1; k <= 5; k++) begin
      step();
      g_rec[k] = grant;
      s_rec[k] = s_out;
      d_rec[k] = done;
      b_rec[k] = busy;
      if (k == 1) set_req = 4'b0000;
    end
    chk("single_grant_c1", g_rec[1], 4'b0100);
    chk("single_grant_c4", g_rec[4], 4'b0100);
    chk("single_s_c1", s_rec[1], 1'b1);
    chk("single_s_c2", s_rec[2], 1'b1);
    chk("single_s_c3", s_rec[3], 1'b0);
    chk("single_done_c3", d_rec[3], 1'b0);
    chk("single_done_c4", d_rec[4], 1'b1);
    chk("single_busy_c5", b_rec[5], 1'b0);
    repeat (2) step();

    // Round-robin from a fresh pointer with 4'b1011 held.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req = 4'b1011;
    prev_busy = busy;
    for (int c = 0; c < 80 && order.size() < 6; c++) begin
      step();
      if (busy && !prev_busy) order.push_back(int'(owner));
      prev_busy = busy;
    end
    chk("rr_count", order.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < order.size()) chk("rr_order", order[k], exp_rr[k]);
    end
    set_req = 4'b0000;
    repeat (8) step();

    // Clear on index 0: only r_out pulses and the latch reads cleared.
    clr_req = 4'b0001;
    seen_s = 0; seen_r = 0; seen_d = 0; q_at_done = 1'bx;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) clr_req = 4'b0000;
      if (s_out) seen_s = 1;
      if (r_out) seen_r = 1;
      if (done) begin seen_d = 1; q_at_done = q_in; end
    end
    chk("clr_r_seen", seen_r, 1'b1);
    chk("clr_s_seen", seen_s, 1'b0);
    chk("clr_done", seen_d, 1'b1);
    chk("clr_q", q_at_done, 1'b0);

    // Set/clear conflict on index 2: set wins.
    set_req = 4'b0100;
    clr_req = 4'b0100;
    seen_s = 0; seen_r = 0; seen_d = 0; q_at_done = 1'bx;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) begin set_req = 4'b0000; clr_req = 4'b0000; end
      if (s_out) seen_s = 1;
      if (r_out) seen_r = 1;
      if (done) begin seen_d = 1; q_at_done = q_in; end
    end
    chk("conf_s_seen", seen_s, 1'b1);
    chk("conf_r_seen", seen_r, 1'b0);
    chk("conf_done", seen_d, 1'b1);
    chk("conf_q", q_at_done, 1'b1);

    // Timeout: rails stuck at 0/0 after a set on index 1.
    stuck = 1'b1;
    set_req = 4'b0010;
    seen_d = 0;
    err_cyc = -1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 1) set_req = 4'b0000;
      if (err && err_cyc < 0) err_cyc = k;
      if (done) seen_d = 1;
    end
    chk("to_err_cycle", err_cyc, 11);
    chk("to_no_done", seen_d, 1'b0);
    stuck = 1'b0;
    // Pointer now at 2, so index 2 beats index 0.
    set_req = 4'b0101;
    step();
    chk("to_ptr_adv", owner, 2'd2);
    set_req = 4'b0000;
    repeat (6) step();

    // Reset in the first pulse cycle, then re-arbitration from pointer 0.
    set_req = 4'b0001;
    step();
    chk("mp_s_before", s_out, 1'b1);
    rst = 1'b1;
    set_req = 4'b1010;
    step();
    chk("mp_s_after", s_out, 1'b0);
    chk("mp_grant_after", grant, 4'b0000);
    chk("mp_no_term", {done, err}, 2'b00);
    rst = 1'b0;
    step();
    chk("mp_regrant", grant, 4'b0010);
    set_req = 4'b0000;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
